// File: rtl/hw3_3_seq_ctrl_pkg.sv
// Shared constants for the hw3_3 vector sequencer: controller state encoding
// and the field layout of one vector RAM entry.
package hw3_3_seq_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_CLR  = 2'b01;
    localparam state_t ST_RUN  = 2'b10;
    localparam state_t ST_DONE = 2'b11;

    // One vector entry is {x, y, z_expected}
    localparam int VEC_W  = 3;
    localparam int X_BIT  = 2;
    localparam int Y_BIT  = 1;
    localparam int ZE_BIT = 0;

endpackage

// File: rtl/hw3_3_vec_ram.sv
// Vector RAM: DEPTH x VEC_W bits, synchronous write, asynchronous read.
// Contents are deliberately not reset so vectors survive a controller reset.
module hw3_3_vec_ram
    import hw3_3_seq_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [VEC_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [VEC_W-1:0] rd_data
);

    localparam int DEPTH = 2**AW;

    logic [VEC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hw3_3_seq_ctrl.sv
// On-chip tester for the two-input Mealy FSM: pulses its reset, replays stored
// {x,y} vectors one per clock and checks the combinational z in the same cycle.
module hw3_3_seq_ctrl
    import hw3_3_seq_ctrl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    output logic          dut_reset,
    output logic          dut_x,
    output logic          dut_y,
    input  logic          dut_z,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err,
    output logic          err_flag
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE   = (AW+1)'(1);

    state_t              state;
    state_t              state_next;
    logic [AW:0]         len_q;
    logic [AW:0]         len_clamped;
    logic [AW-1:0]       idx;
    logic [VEC_W-1:0]    rd_data;
    logic                ram_we;
    logic                in_run;
    logic                mismatch;
    logic                last_vec;

    assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;

    // Writes are blocked while a sequence is being replayed
    assign ram_we = wr_en && !busy;

    hw3_3_vec_ram #(.AW(AW)) u_vec_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    assign in_run    = (state == ST_RUN);
    assign busy      = (state == ST_CLR) || in_run;
    assign done      = (state == ST_DONE);
    assign dut_reset = (state == ST_CLR);
    assign dut_x     = in_run && rd_data[X_BIT];
    assign dut_y     = in_run && rd_data[Y_BIT];
    assign mismatch  = in_run && (dut_z != rd_data[ZE_BIT]);
    assign last_vec  = ({1'b0, idx} == (len_q - LEN_ONE));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CLR;
            ST_CLR:  state_next = (len_q != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (last_vec) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            idx       <= '0;
            err_cnt   <= '0;
            first_err <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == ST_IDLE) && start) begin
                len_q     <= len_clamped;
                idx       <= '0;
                err_cnt   <= '0;
                first_err <= '0;
                err_flag  <= 1'b0;
            end
            // Only the first mismatching address is kept; later ones just count
            if (in_run) begin
                idx <= idx + 1'b1;
                if (mismatch) begin
                    err_cnt <= err_cnt + LEN_ONE;
                    if (!err_flag) begin
                        err_flag  <= 1'b1;
                        first_err <= idx;
                    end
                end
            end
        end
    end

endmodule
